pc_fetch_unit: RTL and testbench

Program-counter register and next-PC sequencer for the MIPS fetch stage. Holds the current fetch address and drives it to instruction memory and to the PC+4 incrementer (`Add`). Takes the incrementer's result back in. Each cycle it selects the next PC from sequential flow, a pending redirect, or a fresh redirect, under stall and a valid/ready fetch handshake.

---
 rtl/mips_pkg.sv | 15 +
 rtl/pc_next_mux.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: default address width, reset PC,
// instruction size and the PC sequencer state encoding.
package mips_pkg;

    localparam int          DEF_WIDTH    = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        PEND = 2'b10
    } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch stage.
// Priority: fresh redirect target, then pending target, then pc_plus4.
// Redirect targets are forced to instruction alignment; the misalignment
// of the raw target is reported so the owner can latch an error flag.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    input  logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] target_aligned,
    output logic             target_misaligned,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

    // Clear the byte-offset bits of the target and flag any that were set.
    always_comb begin
        target_aligned    = redirect_target & ~ALIGN_MASK;
        target_misaligned = |(redirect_target & ALIGN_MASK);
    end

    // Pick the next fetch address in priority order.
    always_comb begin
        next_pc = pc_plus4;
        if (redirect_valid) begin
            next_pc = target_aligned;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and next-PC sequencer for the MIPS fetch stage.
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined   - the instruction at pc when a redirect arrives is a delay slot
//               and is still fetched; the target is applied on a fire, held
//               as pending until then, and flush is never raised.
//   undefined - a redirect replaces pc at the next edge unconditionally and
//               flush pulses for one cycle afterwards.
// The PC+4 incrementer is external: pc feeds it, pc_plus4 returns from it.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_ready,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc,
    output logic             if_valid,
    output logic             flush,
    output logic             redirect_pending,
    output logic             addr_err
);

    pc_state_t        state_r;
    logic [WIDTH-1:0] pc_r;
    logic             if_valid_r;
    logic             flush_r;
    logic             pend_r;
    logic             addr_err_r;
    logic             fire_s;
    logic [WIDTH-1:0] next_pc_s;
    logic [WIDTH-1:0] target_aligned_s;
    logic             target_misaligned_s;
    logic [WIDTH-1:0] pend_target_s;

`ifdef BRANCH_DELAY_SLOT_EN
    logic [WIDTH-1:0] pend_target_r;
    assign pend_target_s = pend_target_r;
`else
    assign pend_target_s = pc_r;
`endif

    assign fire_s = if_valid_r & if_ready & ~stall;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .pend_valid        (pend_r),
        .pend_target       (pend_target_s),
        .pc_plus4          (pc_plus4),
        .target_aligned    (target_aligned_s),
        .target_misaligned (target_misaligned_s),
        .next_pc           (next_pc_s)
    );

    // Sequencer state, PC register, handshake valid, flush pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BOOT;
            pc_r       <= RESET_PC;
            if_valid_r <= 1'b0;
            flush_r    <= 1'b0;
            pend_r     <= 1'b0;
            addr_err_r <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_target_r <= RESET_PC;
`endif
        end else begin
            if (redirect_valid && target_misaligned_s) begin
                addr_err_r <= 1'b1;
            end
`ifdef BRANCH_DELAY_SLOT_EN
            // Delay slot mode: a redirect waits for a fire, so nothing is killed.
            flush_r <= 1'b0;
            case (state_r)
                BOOT: begin
                    if_valid_r <= 1'b1;
                    if (redirect_valid) begin
                        pend_target_r <= target_aligned_s;
                        pend_r        <= 1'b1;
                        state_r       <= PEND;
                    end else begin
                        state_r <= RUN;
                    end
                end
                RUN, PEND: begin
                    if (fire_s) begin
                        pc_r    <= next_pc_s;
                        pend_r  <= 1'b0;
                        state_r <= RUN;
                    end else if (redirect_valid) begin
                        pend_target_r <= target_aligned_s;
                        pend_r        <= 1'b1;
                        state_r       <= PEND;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    if_valid_r <= 1'b0;
                    pend_r     <= 1'b0;
                end
            endcase
`else
            // No delay slot: a redirect takes effect at once and kills IF/ID.
            flush_r <= redirect_valid;
            pend_r  <= 1'b0;
            case (state_r)
                BOOT: begin
                    if_valid_r <= 1'b1;
                    state_r    <= RUN;
                    if (redirect_valid) begin
                        pc_r <= next_pc_s;
                    end
                end
                RUN: begin
                    if (redirect_valid || fire_s) begin
                        pc_r <= next_pc_s;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    if_valid_r <= 1'b1;
                end
            endcase
`endif
        end
    end

    assign pc               = pc_r;
    assign if_valid         = if_valid_r;
    assign flush            = flush_r;
    assign redirect_pending = pend_r;
    assign addr_err         = addr_err_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed test-plan sequence with
// literal expectations, then randomized traffic against a behavioural model.
// Honours BRANCH_DELAY_SLOT_EN the same way as the design.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        flush;
    logic        redirect_pending;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model of the architectural outputs.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_flush;
    logic        m_pend;
    logic        m_err;
    logic [31:0] m_ptgt;

    always #5 clk = ~clk;

    // External incrementer
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .if_ready         (if_ready),
        .pc_plus4         (pc_plus4),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .pc               (pc),
        .if_valid         (if_valid),
        .flush            (flush),
        .redirect_pending (redirect_pending),
        .addr_err         (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the inputs that were applied.
    task automatic model_step(input logic r, input logic s, input logic rd,
                              input logic rv, input logic [31:0] rt);
        logic [31:0] tgt;
        logic        fire;
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_pend = 1'b0; m_err = 1'b0;
            m_ptgt = 32'h0;
        end else begin
            tgt  = {rt[31:2], 2'b00};
            fire = m_valid && rd && !s;
            if (rv && (rt[1:0] != 2'b00)) m_err = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            m_flush = 1'b0;
            if (!m_valid) begin
                if (rv) begin m_pend = 1'b1; m_ptgt = tgt; end
                m_valid = 1'b1;
            end else if (fire) begin
                m_pc   = rv ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
                m_pend = 1'b0;
            end else if (rv) begin
                m_pend = 1'b1; m_ptgt = tgt;
            end
`else
            m_flush = rv;
            if (rv) m_pc = tgt;
            else if (fire) m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
`endif
        end
    endtask

    // Apply one cycle of inputs, clock it, and step the model.
    task automatic cyc(input logic r, input logic s, input logic rd,
                       input logic rv, input logic [31:0] rt);
        rst = r; stall = s; if_ready = rd; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        model_step(r, s, rd, rv, rt);
        #1;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc",       pc,                        m_pc);
            chk("model_if_valid", {31'd0, if_valid},         {31'd0, m_valid});
            chk("model_flush",    {31'd0, flush},            {31'd0, m_flush});
            chk("model_pending",  {31'd0, redirect_pending}, {31'd0, m_pend});
            chk("model_addr_err", {31'd0, addr_err},         {31'd0, m_err});
        end
    end

    initial begin
        logic [31:0] t;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cmp_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_pc",       pc,                        32'h0);
        chk("rst_if_valid", {31'd0, if_valid},         32'd0);
        chk("rst_flush",    {31'd0, flush},            32'd0);
        chk("rst_pending",  {31'd0, redirect_pending}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err},         32'd0);

        // BOOT cycle, then sequential fetch
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("boot_if_valid", {31'd0, if_valid}, 32'd1);
        chk("seq_pc0", pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("seq_pc", pc, 32'(4 * i));
        end

        // Stall holds pc at 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("stall_hold", pc, 32'h10);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_release", pc, 32'h14);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("pc_at_20", pc, 32'h20);

`ifdef BRANCH_DELAY_SLOT_EN
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("pc_at_24", pc, 32'h24);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("ds_pend_set", {31'd0, redirect_pending}, 32'd1);
        chk("ds_pend_hold_pc", pc, 32'h24);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("ds_pend_stalled", pc, 32'h24);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("ds_apply_pc", pc, 32'h200);
        chk("ds_pend_clear", {31'd0, redirect_pending}, 32'd0);
        chk("ds_no_flush", {31'd0, flush}, 32'd0);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        chk("redir_pc", pc, 32'h100);
        chk("redir_flush", {31'd0, flush}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("redir_flush_drop", {31'd0, flush}, 32'd0);
        chk("redir_next", pc, 32'h104);
`endif

        // Misaligned target is aligned and latches addr_err
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h303);
        chk("misalign_pc", pc, 32'h300);
        chk("misalign_err", {31'd0, addr_err}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);

        // Wrap modulo 2^32
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrap_zero", pc, 32'h0);

        // Reset while a redirect is outstanding
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_pending", {31'd0, redirect_pending}, 32'd0);
        chk("rst2_err", {31'd0, addr_err}, 32'd0);
        chk("rst2_flush", {31'd0, flush}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst2_resume", pc, 32'h4);

        // Redirect arriving during BOOT
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h500);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            cyc(($urandom_range(99) == 0),
                ($urandom_range(3) == 0),
                ($urandom_range(3) != 0),
                ($urandom_range(7) == 0),
                t);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
